iir_sine_gen: RTL

//  Recursive 2nd-order IIR resonator (marginally stable poles on unit circle) producing a

---
 rtl/iir_sine_gen_if.sv | 27 ++
 rtl/iir_sine_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/iir_sine_gen_if.sv
// Control, coefficient and sample-stream signals of the IIR sine generator.
// The generator takes the master modport; a controller/consumer takes slave.
interface iir_sine_gen_if #(
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned COEFF_WIDTH  = 16
);
  logic                           start;
  logic                           stop;
  logic signed [COEFF_WIDTH-1:0]  a1;
  logic signed [OUTPUT_WIDTH-1:0] seed;
  logic                           tick;
  logic signed [OUTPUT_WIDTH-1:0] y;
  logic                           y_valid;
  logic                           y_ready;
  logic                           running;
  logic                           overrun;

  modport master (
    input  start, stop, a1, seed, tick, y_ready,
    output y, y_valid, running, overrun
  );

  modport slave (
    output start, stop, a1, seed, tick, y_ready,
    input  y, y_valid, running, overrun
  );
endinterface

// File: rtl/iir_sine_gen.sv
// Marginally stable 2nd-order IIR resonator: y[n] = ((a1*y[n-1]) >>> Q) - y[n-2],
// one sample per accepted tick, saturating feedback, valid/ready output.
module iir_sine_gen #(
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned COEFF_WIDTH  = 16,
  parameter int unsigned Q            = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  iir_sine_gen_if.master bus
);

  localparam int unsigned PW = OUTPUT_WIDTH + COEFF_WIDTH;
  localparam int unsigned SW = OUTPUT_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_MUL,
    S_SUM,
    S_HOLD
  } state_e;

  state_e                         state_q,   state_d;
  logic signed [COEFF_WIDTH-1:0]  a1_q,      a1_d;
  logic signed [OUTPUT_WIDTH-1:0] p_q,       p_d;
  logic signed [OUTPUT_WIDTH-1:0] q_q,       q_d;
  logic signed [PW-1:0]           prod_q,    prod_d;
  logic signed [OUTPUT_WIDTH-1:0] y_q,       y_d;
  logic                           y_valid_q, y_valid_d;
  logic                           running_q, running_d;
  logic                           overrun_q, overrun_d;

  logic signed [PW-1:0]           shifted;
  logic signed [SW-1:0]           diff;
  logic signed [OUTPUT_WIDTH-1:0] sat_val;

  // Next sample: floor-scaled product minus y[n-2], clamped so feedback never wraps
  always_comb begin
    shifted = prod_q >>> Q;
    diff    = SW'(shifted) - SW'(p_q);
    if (diff > SAT_MAX) begin
      sat_val = OUTPUT_WIDTH'(SAT_MAX);
    end else if (diff < SAT_MIN) begin
      sat_val = OUTPUT_WIDTH'(SAT_MIN);
    end else begin
      sat_val = OUTPUT_WIDTH'(diff);
    end
  end

  always_comb begin
    state_d   = state_q;
    a1_d      = a1_q;
    p_d       = p_q;
    q_d       = q_q;
    prod_d    = prod_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        if (bus.tick) begin
          y_d     = p_q;
          prod_d  = PW'(a1_q) * PW'(q_q);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        y_valid_d = 1'b1;
        p_d       = q_q;
        q_d       = sat_val;
        overrun_d = overrun_q | bus.tick;
        state_d   = S_SUM;
      end
      S_SUM: begin
        overrun_d = overrun_q | bus.tick;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        overrun_d = overrun_q | bus.tick;
        if (y_valid_q && bus.y_ready) begin
          y_valid_d = 1'b0;
          state_d   = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.stop) begin
      y_valid_d = 1'b0;
      state_d   = S_IDLE;
    end

    // start outranks stop and tick, from any state
    if (bus.start) begin
      a1_d      = bus.a1;
      p_d       = '0;
      q_d       = bus.seed;
      overrun_d = 1'b0;
      y_valid_d = 1'b0;
      state_d   = S_ARMED;
    end

    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a1_q      <= '0;
      p_q       <= '0;
      q_q       <= '0;
      prod_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      running_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a1_q      <= a1_d;
      p_q       <= p_d;
      q_q       <= q_d;
      prod_q    <= prod_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      running_q <= running_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.running = running_q;
  assign bus.overrun = overrun_q;

endmodule
